// File: rtl/uplink_pkg.sv
// uplink_pkg: FSM encoding, byte tags and sync marker shared by the uplink framer.
// Defining UPLINK_SYNC_EN adds the SEND_SYNC state.
package uplink_pkg;
  localparam logic [2:0] TAG_LO = 3'b000;
  localparam logic [2:0] TAG_HI = 3'b111;
  localparam logic [7:0] SYNC_BYTE = 8'h5A;
`ifdef UPLINK_SYNC_EN
  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI, SEND_SYNC} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;
`endif
  function automatic logic [7:0] lo_byte(input logic [4:0] s);
    return {TAG_LO, s};
  endfunction
  function automatic logic [7:0] hi_byte(input logic [4:0] s);
    return {TAG_HI, s};
  endfunction
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: single-clock sample buffer with a registered first word.
// The head word moves into an output register one cycle after it lands in memory.
module sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic wr, ld;
  assign level = cnt + (AW+1)'(valid);
  assign full = level == (AW+1)'(DEPTH);
  // a pop on the same edge frees a slot, so a push into a full buffer is still taken
  assign wr = push && (!full || pop);
  assign ld = (!valid || pop) && cnt != '0;
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      valid <= 1'b0;
      dout <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (ld) begin
        dout <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      valid <= ld || (valid && !pop);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(ld);
    end
endmodule

// File: rtl/sample_uplink_framer.sv
// sample_uplink_framer: buffers 10-bit ADC samples and writes them as LO/HI byte pairs to a JTAG UART over Avalon-MM.
// Defining UPLINK_SYNC_EN inserts a sync byte after every SYNC_PERIOD pairs.
module sample_uplink_framer
  import uplink_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_PERIOD = 24
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [9:0]                    sample_in,
  input  logic                          sample_valid,
  input  logic                          clear_overflow,
  output logic                          avm_chipselect,
  output logic                          avm_address,
  output logic                          avm_write,
  output logic [31:0]                   avm_writedata,
  input  logic                          avm_waitrequest,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SYNC_PERIOD < 1) begin : g_bad_cfg
    $error("sample_uplink_framer: FIFO_DEPTH must be a power of 2 >= 4 and SYNC_PERIOD >= 1");
  end
  state_t state;
  logic [9:0] f_dout;
  logic f_valid, f_full, pop, drop;
  logic [7:0] byte_q;
  logic [4:0] held;
`ifdef UPLINK_SYNC_EN
  localparam int SW = $clog2(SYNC_PERIOD + 1);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_PERIOD - 1);
  logic [SW-1:0] sync_cnt;
`endif
  assign avm_chipselect = 1'b1;
  assign avm_address = 1'b0;
  assign avm_writedata = {24'b0, byte_q};
  assign pop = state == IDLE && enable && f_valid;
  assign drop = sample_valid && f_full && !pop;
  sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(10)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(sample_valid),
    .pop(pop),
    .din(sample_in),
    .dout(f_dout),
    .valid(f_valid),
    .full(f_full),
    .level(fifo_level)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      avm_write <= 1'b0;
      byte_q <= '0;
      held <= '0;
      overflow <= 1'b0;
`ifdef UPLINK_SYNC_EN
      sync_cnt <= '0;
`endif
    end else begin
      overflow <= drop || (overflow && !clear_overflow);
      case (state)
        IDLE: if (pop) begin
          held <= f_dout[9:5];
          byte_q <= lo_byte(f_dout[4:0]);
          avm_write <= 1'b1;
          state <= SEND_LO;
        end
        SEND_LO: if (!avm_waitrequest) begin
          byte_q <= hi_byte(held);
          state <= SEND_HI;
        end
`ifdef UPLINK_SYNC_EN
        SEND_HI: if (!avm_waitrequest) begin
          sync_cnt <= sync_cnt == SYNC_LAST ? '0 : sync_cnt + 1'b1;
          if (sync_cnt == SYNC_LAST) begin
            byte_q <= SYNC_BYTE;
            state <= SEND_SYNC;
          end else begin
            avm_write <= 1'b0;
            state <= IDLE;
          end
        end
        SEND_SYNC: if (!avm_waitrequest) begin
          avm_write <= 1'b0;
          state <= IDLE;
        end
`else
        SEND_HI: if (!avm_waitrequest) begin
          avm_write <= 1'b0;
          state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sample_uplink_framer.sv
// tb_sample_uplink_framer: directed and random stimulus against a byte-stream reference model.
// Define UPLINK_SYNC_EN for both bench and RTL to exercise sync markers.
module tb_sample_uplink_framer;
  logic clk = 0, reset_n = 0, enable = 0, sample_valid = 0, clear_overflow = 0, avm_waitrequest = 0;
  logic [9:0] sample_in = '0;
  logic avm_chipselect, avm_address, avm_write, overflow;
  logic [31:0] avm_writedata;
  logic [4:0] fifo_level;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] got[$], exp_q[$];
  logic [31:0] wlog = '0, prev_data = '0;
  logic prev_stall = 0;
  logic [9:0] v[17];
`ifdef UPLINK_SYNC_EN
  int pairs = 0;
`endif
  sample_uplink_framer dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sample_in(sample_in),
    .sample_valid(sample_valid), .clear_overflow(clear_overflow),
    .avm_chipselect(avm_chipselect), .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .overflow(overflow), .fifo_level(fifo_level)
  );
  always #10 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
    end
  endtask
  // byte monitor and stall-stability watcher, sampled between active edges
  always @(negedge clk) begin
    if (reset_n && prev_stall) begin
      check("hold_write", avm_write, 1);
      check("hold_data", avm_writedata, prev_data);
    end
    prev_stall = reset_n && avm_write && avm_waitrequest;
    prev_data = avm_writedata;
    wlog = {wlog[30:0], avm_write};
    if (reset_n && avm_write && !avm_waitrequest) begin
      got.push_back(avm_writedata[7:0]);
      check("upper_zero", avm_writedata[31:8], 0);
    end
  end
  function automatic void model_push(input int s);
    exp_q.push_back(8'(s % 32));
    exp_q.push_back(8'(224 + s / 32));
`ifdef UPLINK_SYNC_EN
    pairs++;
    if (pairs % 24 == 0) exp_q.push_back(8'h5A);
`endif
  endfunction
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input logic [9:0] s);
    sample_in = s;
    sample_valid = 1;
    cyc();
    sample_valid = 0;
  endtask
  task automatic wait_write(input string tag);
    int t = 0;
    while (!avm_write && t < 20) begin
      cyc();
      t++;
    end
    check(tag, avm_write, 1);
  endtask
  task automatic drain(input string tag);
    int t = 0;
    while (got.size() < exp_q.size() && t < 3000) begin
      cyc();
      t++;
    end
    cyc(8);
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask
  task automatic do_reset();
    reset_n = 0;
    enable = 0;
    sample_valid = 0;
    clear_overflow = 0;
    avm_waitrequest = 0;
    cyc(2);
    reset_n = 1;
    cyc();
    got.delete();
    exp_q.delete();
`ifdef UPLINK_SYNC_EN
    pairs = 0;
`endif
  endtask
  initial begin
    logic [9:0] a, b, x;
    cyc(2);
    check("rst_write", avm_write, 0);
    check("rst_data", avm_writedata, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    check("chipselect", avm_chipselect, 1);
    check("address", avm_address, 0);
    reset_n = 1;
    cyc();
    enable = 1;
    push(10'h2A5);
    cyc(5);
    check("latency_write", wlog[4:0], 5'b00110);
    model_push(10'h2A5);
    drain("single");
    a = 10'($urandom);
    b = 10'($urandom);
    push(a);
    push(b);
    cyc(7);
    check("b2b_write", wlog[7:0], 8'b00110110);
    model_push(a);
    model_push(b);
    drain("b2b");
    a = 10'($urandom);
    avm_waitrequest = 1;
    push(a);
    wait_write("stall_start");
    for (int i = 0; i < 5; i++) begin
      check("stall_lo", avm_writedata[7:0], 8'(a % 32));
      cyc();
    end
    avm_waitrequest = 0;
    check("stall_lo", avm_writedata[7:0], 8'(a % 32));
    model_push(a);
    drain("stall");
    a = 10'($urandom);
    b = 10'($urandom);
    avm_waitrequest = 1;
    push(a);
    push(b);
    wait_write("en_start");
    enable = 0;
    avm_waitrequest = 0;
    cyc(10);
    check("en_low_bytes", got.size(), 2);
    check("en_low_level", fifo_level, 1);
    enable = 1;
    model_push(a);
    model_push(b);
    drain("enable");
    do_reset();
    for (int i = 0; i < 17; i++) begin
      v[i] = 10'($urandom);
      push(v[i]);
    end
    check("ovf_set", overflow, 1);
    check("ovf_level", fifo_level, 16);
    sample_valid = 1;
    clear_overflow = 1;
    cyc();
    check("ovf_set_wins", overflow, 1);
    sample_valid = 0;
    cyc();
    check("ovf_cleared", overflow, 0);
    clear_overflow = 0;
    x = 10'($urandom);
    avm_waitrequest = 1;
    enable = 1;
    push(x);
    check("pushpop_ovf", overflow, 0);
    check("pushpop_level", fifo_level, 16);
    avm_waitrequest = 0;
    for (int i = 0; i < 16; i++) model_push(v[i]);
    model_push(x);
    drain("overflow");
    check("ovf_empty", fifo_level, 0);
    a = 10'($urandom);
    b = 10'($urandom);
    push(a);
    push(b);
    while (!(avm_write && avm_writedata[7:5] == 3'b000)) cyc();
    cyc();
    avm_waitrequest = 1;
    check("mid_hi_tag", avm_writedata[7:5], 3'b111);
    #4 reset_n = 0;
    #1;
    check("mid_rst_write", avm_write, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_data", avm_writedata, 0);
    cyc(2);
    reset_n = 1;
    avm_waitrequest = 0;
    cyc(10);
    exp_q.push_back(8'(a % 32));
    drain("mid_reset");
`ifdef UPLINK_SYNC_EN
    pairs = 0;
`endif
    do_reset();
    enable = 1;
    for (int s = 0; s < 48; s++) begin
      push(10'(s));
      model_push(s);
      cyc(3);
    end
    drain("seq48");
    for (int i = 0; i < 400; i++) begin
      sample_valid = $urandom_range(7) == 0;
      sample_in = 10'($urandom);
      avm_waitrequest = $urandom_range(3) == 0;
      if (sample_valid) model_push(int'(sample_in));
      cyc();
    end
    sample_valid = 0;
    avm_waitrequest = 0;
    drain("random");
    check("rand_ovf", overflow, 0);
    check("rand_level", fifo_level, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
